// File: rtl/inert_rd_seq.sv
// Inertial sensor read sequencer: power-up wait, three config writes over SPI,
// then a low/high yaw-rate byte read on every data-ready interrupt.
//
// state    | meaning
// PWR_WAIT | counting out sensor power-up time
// CFG_W0   | first config write outstanding
// CFG_W1   | second config write outstanding
// CFG_W2   | third config write outstanding
// IDLE     | configured, waiting for interrupt or pending read
// RD_L     | yaw-rate low byte read outstanding
// RD_H     | yaw-rate high byte read outstanding
module inert_rd_seq #(
   parameter int unsigned PWR_W = 16,
   parameter logic [15:0] CFG0  = 16'h0D02,
   parameter logic [15:0] CFG1  = 16'h1160,
   parameter logic [15:0] CFG2  = 16'h1460
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        INT,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic        wrt,
   output logic [15:0] wrt_data,
   output logic [15:0] yaw_rt,
   output logic        vld,
   output logic        cfg_done
);

   typedef enum logic [2:0] {
      PWR_WAIT = 3'd0,
      CFG_W0   = 3'd1,
      CFG_W1   = 3'd2,
      CFG_W2   = 3'd3,
      IDLE     = 3'd4,
      RD_L     = 3'd5,
      RD_H     = 3'd6
   } state_t;

   localparam logic [PWR_W-1:0] CNT_ONE = PWR_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PWR_W-1:0] r_cnt;
   logic             r_int_s1;
   logic             r_int_s2;
   logic             r_int_s3;
   logic             r_pend;
   logic             r_wrt;
   logic [15:0]      r_wrt_data;
   logic [7:0]       r_yaw_l;
   logic [15:0]      r_yaw_rt;
   logic             r_vld;
   logic             r_cfg_done;

   logic             w_int_rise;
   logic             w_pwr_done;
   logic             w_xfer_done;
   logic             w_rd_start;
   logic             w_wrt_nxt;
   logic [15:0]      w_wrt_data_nxt;
   logic [7:0]       w_yaw_l_nxt;
   logic [15:0]      w_yaw_rt_nxt;
   logic             w_vld_nxt;
   logic             w_cfg_done_nxt;
   logic             w_pend_nxt;

   assign w_int_rise  = r_int_s2 & ~r_int_s3;
   assign w_pwr_done  = &r_cnt;
   // done in the wrt cycle is a leftover from the previous transaction
   assign w_xfer_done = done & ~r_wrt;
   assign w_rd_start  = w_int_rise | r_pend;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= PWR_WAIT;
         r_cnt      <= '0;
         r_int_s1   <= 1'b0;
         r_int_s2   <= 1'b0;
         r_int_s3   <= 1'b0;
         r_pend     <= 1'b0;
         r_wrt      <= 1'b0;
         r_wrt_data <= 16'h0000;
         r_yaw_l    <= 8'h00;
         r_yaw_rt   <= 16'h0000;
         r_vld      <= 1'b0;
         r_cfg_done <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         if ((r_state == PWR_WAIT) && !w_pwr_done)
            r_cnt <= r_cnt + CNT_ONE;
         r_int_s1   <= INT;
         r_int_s2   <= r_int_s1;
         r_int_s3   <= r_int_s2;
         r_pend     <= w_pend_nxt;
         r_wrt      <= w_wrt_nxt;
         r_wrt_data <= w_wrt_data_nxt;
         r_yaw_l    <= w_yaw_l_nxt;
         r_yaw_rt   <= w_yaw_rt_nxt;
         r_vld      <= w_vld_nxt;
         r_cfg_done <= w_cfg_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         PWR_WAIT: if (w_pwr_done)  w_state_nxt = CFG_W0;
         CFG_W0:   if (w_xfer_done) w_state_nxt = CFG_W1;
         CFG_W1:   if (w_xfer_done) w_state_nxt = CFG_W2;
         CFG_W2:   if (w_xfer_done) w_state_nxt = IDLE;
         IDLE:     if (w_rd_start)  w_state_nxt = RD_L;
         RD_L:     if (w_xfer_done) w_state_nxt = RD_H;
         RD_H:     if (w_xfer_done) w_state_nxt = IDLE;
         default:                   w_state_nxt = PWR_WAIT;
      endcase
   end

   always_comb begin
      w_wrt_nxt      = 1'b0;
      w_wrt_data_nxt = r_wrt_data;
      w_yaw_l_nxt    = r_yaw_l;
      w_yaw_rt_nxt   = r_yaw_rt;
      w_vld_nxt      = 1'b0;
      w_cfg_done_nxt = r_cfg_done;
      // interrupts seen outside IDLE collapse into a single pending read
      w_pend_nxt     = (r_state == IDLE) ? 1'b0 : (r_pend | w_int_rise);
      case (r_state)
         PWR_WAIT: if (w_pwr_done) begin
            w_wrt_nxt      = 1'b1;
            w_wrt_data_nxt = CFG0;
         end
         CFG_W0: if (w_xfer_done) begin
            w_wrt_nxt      = 1'b1;
            w_wrt_data_nxt = CFG1;
         end
         CFG_W1: if (w_xfer_done) begin
            w_wrt_nxt      = 1'b1;
            w_wrt_data_nxt = CFG2;
         end
         CFG_W2: if (w_xfer_done) w_cfg_done_nxt = 1'b1;
         IDLE: if (w_rd_start) begin
            w_wrt_nxt      = 1'b1;
            w_wrt_data_nxt = 16'hA600;
         end
         RD_L: if (w_xfer_done) begin
            w_yaw_l_nxt    = rd_data[7:0];
            w_wrt_nxt      = 1'b1;
            w_wrt_data_nxt = 16'hA700;
         end
         RD_H: if (w_xfer_done) begin
            w_yaw_rt_nxt   = {rd_data[7:0], r_yaw_l};
            w_vld_nxt      = 1'b1;
         end
         default: ;
      endcase
   end

   assign wrt      = r_wrt;
   assign wrt_data = r_wrt_data;
   assign yaw_rt   = r_yaw_rt;
   assign vld      = r_vld;
   assign cfg_done = r_cfg_done;

endmodule

// File: tb/tb_inert_rd_seq.sv
// Directed bench for inert_rd_seq: a small SPI monarch model answers A6/A7
// reads and logs every command, wrt pulse and vld pulse for the checks.
module tb_inert_rd_seq;

   logic        clk;
   logic        rst_n;
   logic        INT;
   logic        done;
   logic [15:0] rd_data;
   logic        wrt;
   logic [15:0] wrt_data;
   logic [15:0] yaw_rt;
   logic        vld;
   logic        cfg_done;

   inert_rd_seq #(.PWR_W(4)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .INT      (INT),
      .done     (done),
      .rd_data  (rd_data),
      .wrt      (wrt),
      .wrt_data (wrt_data),
      .yaw_rt   (yaw_rt),
      .vld      (vld),
      .cfg_done (cfg_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [15:0] cmd_q[$];
   int          cyc_q[$];
   int          cyc       = 0;
   int          lat       = 0;
   int          vld_cnt   = 0;
   int          vld_dbl   = 0;
   int          vld_early = 0;
   int          wrt_dbl   = 0;
   logic        prev_wrt  = 1'b0;
   logic        prev_vld  = 1'b0;
   logic        hold_done = 1'b0;

   // monarch model and monitor, acting just after each rising edge
   initial begin
      done    = 1'b0;
      rd_data = 16'h0000;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (hold_done) done = 1'b1;
         if (!rst_n) begin
            lat = 0;
            if (!hold_done) done = 1'b0;
         end else if (wrt) begin
            cmd_q.push_back(wrt_data);
            cyc_q.push_back(cyc);
            if (prev_wrt) wrt_dbl++;
            rd_data = (wrt_data[15:8] == 8'hA6) ? 16'h00CD :
                      (wrt_data[15:8] == 8'hA7) ? 16'h00AB : 16'h0000;
            if (!hold_done) begin
               done = 1'b0;
               lat  = 4;
            end
         end else if (lat > 0) begin
            lat--;
            if (lat == 0) done = 1'b1;
         end
         if (vld) begin
            vld_cnt++;
            if (prev_vld)  vld_dbl++;
            if (!cfg_done) vld_early++;
         end
         prev_wrt = wrt;
         prev_vld = vld;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clear_log();
      cmd_q.delete();
      cyc_q.delete();
      vld_cnt   = 0;
      vld_dbl   = 0;
      vld_early = 0;
      wrt_dbl   = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_int();
      INT = 1'b1;
      idle(2);
      INT = 1'b0;
   endtask

   task automatic wait_cmds(input int n, input int budget);
      for (int i = 0; i < budget && cmd_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic wait_vld(input int n, input int budget);
      for (int i = 0; i < budget && vld_cnt < n; i++) @(negedge clk);
   endtask

   task automatic wait_cfg(input int budget);
      for (int i = 0; i < budget && !cfg_done; i++) @(negedge clk);
   endtask

   // counts negedges from reset release to the first wrt
   task automatic count_pwr(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n++;
         if (wrt) break;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      clear_log();
      rst_n = 1'b1;
   endtask

   int n_pwr;

   initial begin
      rst_n = 1'b0;
      INT   = 1'b0;
      idle(3);
      chk("rst_wrt", wrt, 0);
      chk("rst_wrt_data", wrt_data, 16'h0000);
      chk("rst_yaw", yaw_rt, 16'h0000);
      chk("rst_vld", vld, 0);
      chk("rst_cfg_done", cfg_done, 0);

      // power-up wait and config sequence
      clear_log();
      rst_n = 1'b1;
      count_pwr(n_pwr);
      chk("pwr_cycles", n_pwr, 16);
      chk("cfg0_data", wrt_data, 16'h0D02);
      chk("cfg_done_early", cfg_done, 0);
      wait_cfg(100);
      chk("cfg_done", cfg_done, 1);
      chk("cfg_cnt", cmd_q.size(), 3);
      chk("cfg1_data", cmd_q[1], 16'h1160);
      chk("cfg2_data", cmd_q[2], 16'h1460);
      chk("cfg_gap", cyc_q[1] - cyc_q[0], 5);
      chk("cfg_wrt_width", wrt_dbl, 0);

      // single interrupt-driven read
      idle(3);
      clear_log();
      pulse_int();
      wait_vld(1, 100);
      chk("rd_vld_hi", vld, 1);
      chk("rd_yaw", yaw_rt, 16'hABCD);
      chk("rd_cnt", cmd_q.size(), 2);
      chk("rd_lo_cmd", cmd_q[0], 16'hA600);
      chk("rd_hi_cmd", cmd_q[1], 16'hA700);
      idle(1);
      chk("rd_vld_lo", vld, 0);
      idle(20);
      chk("rd_vld_cnt", vld_cnt, 1);
      chk("rd_yaw_hold", yaw_rt, 16'hABCD);

      // interrupt during RD_L becomes a pending read
      clear_log();
      pulse_int();
      wait_cmds(1, 50);
      pulse_int();
      wait_vld(2, 200);
      idle(30);
      chk("pend_vld_cnt", vld_cnt, 2);
      chk("pend_cmd_cnt", cmd_q.size(), 4);
      chk("pend_rd2_cmd", cmd_q[2], 16'hA600);
      chk("pend_vld_width", vld_dbl, 0);
      chk("pend_wrt_width", wrt_dbl, 0);

      // reset while the high-byte read is outstanding
      clear_log();
      pulse_int();
      wait_cmds(2, 100);
      chk("rdh_cmd", cmd_q[1], 16'hA700);
      rst_n = 1'b0;
      idle(1);
      chk("rdh_rst_wrt", wrt, 0);
      chk("rdh_rst_vld", vld, 0);
      chk("rdh_rst_yaw", yaw_rt, 16'h0000);
      chk("rdh_rst_cfg_done", cfg_done, 0);
      clear_log();
      rst_n = 1'b1;
      count_pwr(n_pwr);
      chk("rdh_pwr_cycles", n_pwr, 16);
      chk("rdh_cfg0_data", wrt_data, 16'h0D02);
      wait_cfg(100);
      idle(10);
      chk("rdh_no_vld", vld_cnt, 0);
      chk("rdh_cmd_cnt", cmd_q.size(), 3);

      // interrupt during power-up is serviced after config
      do_reset();
      idle(2);
      pulse_int();
      idle(5);
      chk("pw_no_wrt", cmd_q.size(), 0);
      wait_vld(1, 200);
      idle(20);
      chk("pw_cmd_cnt", cmd_q.size(), 5);
      chk("pw_cfg0", cmd_q[0], 16'h0D02);
      chk("pw_cfg2", cmd_q[2], 16'h1460);
      chk("pw_rd_lo", cmd_q[3], 16'hA600);
      chk("pw_rd_hi", cmd_q[4], 16'hA700);
      chk("pw_vld_cnt", vld_cnt, 1);
      chk("pw_vld_early", vld_early, 0);
      chk("pw_yaw", yaw_rt, 16'hABCD);

      // done held high: wrt cycles must not consume the stale done
      hold_done = 1'b1;
      do_reset();
      wait_cfg(100);
      chk("hd_cfg_done", cfg_done, 1);
      chk("hd_cfg_cnt", cmd_q.size(), 3);
      chk("hd_gap0", cyc_q[1] - cyc_q[0], 2);
      chk("hd_gap1", cyc_q[2] - cyc_q[1], 2);
      chk("hd_cfg2", cmd_q[2], 16'h1460);
      chk("hd_wrt_width", wrt_dbl, 0);
      idle(3);
      clear_log();
      pulse_int();
      wait_vld(1, 100);
      idle(10);
      chk("hd_rd_cnt", cmd_q.size(), 2);
      chk("hd_rd_gap", cyc_q[1] - cyc_q[0], 2);
      chk("hd_yaw", yaw_rt, 16'hABCD);
      chk("hd_vld_cnt", vld_cnt, 1);
      chk("hd_wrt_width2", wrt_dbl, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
